// File: rtl/id_hazard_scoreboard_if.sv
// IF/ID issue-side bundle for id_hazard_scoreboard; instruction vectors use
// bit 0 = MSB numbering to match the ISA field layout.
interface id_hazard_scoreboard_if;
  logic [0:31] IF_instruction;
  logic        IF_valid;
  logic        flush;
  logic [0:31] ID_instruction;
  logic        ID_issue;
  logic        IF_stall;
  logic [31:0] busy_mask;
  logic [15:0] stall_count;

  modport master (
    output IF_instruction, IF_valid, flush,
    input  ID_instruction, ID_issue, IF_stall, busy_mask, stall_count
  );

  modport slave (
    input  IF_instruction, IF_valid, flush,
    output ID_instruction, ID_issue, IF_stall, busy_mask, stall_count
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Issue scoreboard between IF and ID: per-register write-back countdowns gate
// dependent reads. Optional stall statistic enabled by defining STALL_CNT_EN.
module id_hazard_scoreboard #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 4
) (
  input logic                   clk,
  input logic                   rst,
  id_hazard_scoreboard_if.slave bus
);

  localparam logic [5:0]  OP_ALU   = 6'b101010;
  localparam logic [5:0]  OP_LOAD  = 6'b100000;
  localparam logic [5:0]  OP_STORE = 6'b100001;
  localparam logic [0:31] NOP_INSN = 32'hF000_0000;

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_e;

  logic [CNT_W-1:0] cnt_r [32];
  logic [31:0]      busy_s;
  logic [5:0]       opcode_s;
  logic [4:0]       rd_s;
  logic [4:0]       ra_s;
  logic [4:0]       rb_s;
  logic [3:0]       func_s;
  logic [4:0]       src_a_s;
  logic             src_a_vld_s;
  logic             src_b_vld_s;
  logic             dst_vld_s;
  logic             hazard_s;
  logic             issue_s;
  state_e           state_r;
  state_e           state_next_s;

  assign opcode_s = bus.IF_instruction[0:5];
  assign rd_s     = bus.IF_instruction[6:10];
  assign ra_s     = bus.IF_instruction[11:15];
  assign rb_s     = bus.IF_instruction[16:20];
  assign func_s   = bus.IF_instruction[28:31];

  // Decode which register fields are read and which one is written.
  always_comb begin
    src_a_s     = ra_s;
    src_a_vld_s = 1'b0;
    src_b_vld_s = 1'b0;
    dst_vld_s   = 1'b0;
    case (opcode_s)
      OP_ALU: begin
        src_a_vld_s = 1'b1;
        src_b_vld_s = !((func_s == 4'b1011) || (func_s == 4'b1101) || (func_s == 4'b1111));
        dst_vld_s   = 1'b1;
      end
      OP_LOAD: begin
        dst_vld_s = 1'b1;
      end
      OP_STORE: begin
        src_a_s     = rd_s;
        src_a_vld_s = 1'b1;
      end
      default: begin
        src_a_vld_s = 1'b0;
      end
    endcase
  end

  // Busy view of the counters; r0 is hardwired clear so it never hazards.
  always_comb begin
    busy_s = 32'h0000_0000;
    for (int r = 1; r < 32; r++) begin
      busy_s[r] = (cnt_r[r] != {CNT_W{1'b0}});
    end
  end

  assign hazard_s = bus.IF_valid && !bus.flush &&
                    ((src_a_vld_s && busy_s[src_a_s]) || (src_b_vld_s && busy_s[rb_s]));
  assign issue_s  = bus.IF_valid && !bus.flush && !hazard_s;

  assign bus.IF_stall       = hazard_s;
  assign bus.ID_issue       = issue_s;
  assign bus.ID_instruction = issue_s ? bus.IF_instruction : NOP_INSN;
  assign bus.busy_mask      = busy_s;

  // Countdown per register; an issuing write reloads its destination (WAW wins over decrement).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (issue_s && dst_vld_s && (rd_s != 5'd0) && (rd_s == 5'(r))) begin
          cnt_r[r] <= CNT_W'(WB_LAT);
        end else if (cnt_r[r] != {CNT_W{1'b0}}) begin
          cnt_r[r] <= cnt_r[r] - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Issue FSM next state; a killed or empty slot always returns to RUN.
  always_comb begin
    state_next_s = state_r;
    if (!bus.IF_valid || bus.flush) begin
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN:     state_next_s = hazard_s ? STALL : RUN;
        STALL:   state_next_s = hazard_s ? STALL : RUN;
        default: state_next_s = RUN;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (hazard_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_count = stall_cnt_r;
`else
  assign bus.stall_count = 16'h0000;
`endif

endmodule
